// File: rtl/seg7_dynamic_to_static.sv
// Converts a scanned (multiplexed) 7-segment drive into per-digit static outputs,
// with optional stale-digit blanking and PWM brightness control.
module seg7_dynamic_to_static #(
    parameter int w_digit        = 4,
    parameter int seg_active_low = 1,
    parameter int dp_active_low  = 0,
    parameter int stale_cycles   = 0,
    parameter int w_pwm          = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode_direct,
    input  logic [w_pwm-1:0]       brightness,
    input  logic [7:0]             abcdefgh,
    input  logic [w_digit-1:0]     digit,
    output logic [7*w_digit-1:0]   hex,
    output logic [w_digit-1:0]     dp
);
    localparam logic SEG_INV = (seg_active_low != 0);
    localparam logic DP_INV  = (dp_active_low != 0);

    logic [7:0]           w_pattern;
    logic [7:0]           r_store     [w_digit];
    logic [7:0]           w_store_nxt [w_digit];
    logic [w_digit-1:0]   r_valid;
    logic [w_digit-1:0]   w_valid_nxt;
    logic [w_digit-1:0]   w_stale;
    logic [w_pwm-1:0]     r_pwm_cnt;
    logic                 w_enable;
    logic [7*w_digit-1:0] r_hex;
    logic [7*w_digit-1:0] w_hex_nxt;
    logic [w_digit-1:0]   r_dp;
    logic [w_digit-1:0]   w_dp_nxt;

    // Reverse a..dp into g..a in bits [6:0], dp in bit 7.
    always_comb begin
        for (int j = 0; j < 8; j++) w_pattern[j] = abcdefgh[7-j];
    end

    always_comb begin
        for (int i = 0; i < w_digit; i++) begin
            // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
            w_store_nxt[i] = r_store[i];
            w_valid_nxt[i] = r_valid[i];
            if (digit[i]) begin
                w_store_nxt[i] = w_pattern;
                w_valid_nxt[i] = 1'b1;
            end else if (mode_direct || w_stale[i]) begin
                w_store_nxt[i] = '0;
                w_valid_nxt[i] = 1'b0;
            end
        end
    end

    generate
        if (stale_cycles > 0) begin : g_stale
            localparam int            CW    = $clog2(stale_cycles + 1);
            localparam logic [CW-1:0] LIMIT = CW'(stale_cycles);

            logic [CW-1:0] r_cnt     [w_digit];
            logic [CW-1:0] w_cnt_nxt [w_digit];

            // Saturating idle counter; the digit is dropped on the edge the count reaches LIMIT.
            always_comb begin
                for (int i = 0; i < w_digit; i++) begin
                    if (digit[i])
                        w_cnt_nxt[i] = '0;
                    else if (r_cnt[i] == LIMIT)
                        w_cnt_nxt[i] = r_cnt[i];
                    else
                        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                    w_stale[i] = !digit[i] && (w_cnt_nxt[i] == LIMIT);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < w_digit; i++) r_cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < w_digit; i++) r_cnt[i] <= w_cnt_nxt[i];
                end
            end
        end else begin : g_no_stale
            assign w_stale = '0;
        end
    endgenerate

    assign w_enable = (&brightness) || (r_pwm_cnt < brightness);

    // Outputs are built from the next-state store so the display lags the inputs by one clock.
    always_comb begin
        w_hex_nxt = {(7*w_digit){SEG_INV}};
        w_dp_nxt  = {w_digit{DP_INV}};
        for (int i = 0; i < w_digit; i++) begin
            if (w_valid_nxt[i] && w_enable) begin
                w_hex_nxt[7*i +: 7] = w_store_nxt[i][6:0] ^ {7{SEG_INV}};
                w_dp_nxt[i]         = w_store_nxt[i][7] ^ DP_INV;
            end
        end
    end

    // NOTE: the store array is small and must be cleared on reset, so it is a reset register file, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < w_digit; i++) r_store[i] <= '0;
            r_valid   <= '0;
            r_pwm_cnt <= '0;
            r_hex     <= {(7*w_digit){SEG_INV}};
            r_dp      <= {w_digit{DP_INV}};
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < w_digit; i++) r_store[i] <= w_store_nxt[i];
            r_valid   <= w_valid_nxt;
            r_pwm_cnt <= r_pwm_cnt + w_pwm'(1);
            r_hex     <= w_hex_nxt;
            r_dp      <= w_dp_nxt;
        end
    end

    assign hex = r_hex;
    assign dp  = r_dp;
endmodule
